// File: rtl/camera_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : camera_frame_source
// Description : Synthetic camera front-end. Generates MIPI pixel-port style
//               vertical sync, horizontal sync and a selectable test pattern,
//               one pixel per clock, while the level request 'run' is high.
//               A frame is V_BLANK blank lines followed by V_ACTIVE active
//               lines; each line is H_ACTIVE pixels plus H_BLANK blanking.
//               Frames are never truncated by dropping 'run'.
// Ports       : clk           - pixel clock, rising edge
//               reset         - asynchronous reset, active low
//               run           - level request, frames produced while high
//               pattern_sel   - test pattern select, latched at frame start
//               MIPI_PIXEL_VS - high over the active lines of a frame
//               MIPI_PIXEL_HS - high over the active pixels of a line
//               MIPI_PIXEL_D  - pixel data, 0 outside VS&HS
//               frame_start   - 1-cycle pulse with the first active pixel
//               frame_done    - 1-cycle pulse on the cycle VS falls
// Options     : CAMSRC_FRAME_TAG_EN - when defined, an 8-bit frame counter
//               replaces pixel (0,0) of every frame with the frame number.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_frame_source #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int D_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [1:0]     pattern_sel,
  output logic           MIPI_PIXEL_VS,
  output logic           MIPI_PIXEL_HS,
  output logic [D_W-1:0] MIPI_PIXEL_D,
  output logic           frame_start,
  output logic           frame_done
);

  localparam int          LINE_LEN     = H_ACTIVE + H_BLANK;
  localparam logic [15:0] H_LAST       = 16'(LINE_LEN - 1);
  localparam logic [15:0] H_ACT        = 16'(H_ACTIVE);
  localparam logic [15:0] VBLANK_LAST  = 16'(V_BLANK - 1);
  localparam logic [15:0] VACTIVE_LAST = 16'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    h_cnt_q, h_cnt_d;
  logic [15:0]    v_cnt_q, v_cnt_d;
  logic [1:0]     pat_q, pat_d;

  logic           vs_q, vs_d;
  logic           hs_q, hs_d;
  logic [D_W-1:0] data_q, data_d;
  logic           fstart_q, fstart_d;
  logic           fdone_q, fdone_d;

  logic [D_W-1:0] pixel_val;
  logic           in_active;
  logic           h_wrap;

`ifdef CAMSRC_FRAME_TAG_EN
  logic [7:0]     frame_cnt_q;
`endif

  assign in_active = (state_q == ST_ACTIVE);
  assign h_wrap    = (h_cnt_q == H_LAST);

  // Test pattern for the pixel the state/counters currently address.
  always_comb begin
    pixel_val = '0;
    case (pat_q)
      2'd0:    pixel_val = h_cnt_q[D_W-1:0];
      2'd1:    pixel_val = v_cnt_q[D_W-1:0];
      2'd2:    pixel_val = {D_W{h_cnt_q[3] ^ v_cnt_q[3]}};
      default: pixel_val = h_cnt_q[D_W-1:0] ^ v_cnt_q[D_W-1:0];
    endcase
`ifdef CAMSRC_FRAME_TAG_EN
    if ((h_cnt_q == 16'd0) && (v_cnt_q == 16'd0)) begin
      pixel_val = D_W'(frame_cnt_q);
    end
`endif
  end

  // Next-state logic. v_cnt restarts at 0 on every region change so that in
  // ACTIVE it is directly the active line index used by the patterns.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    pat_d   = pat_q;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run) begin
          state_d = ST_VBLANK;
        end
      end
      ST_VBLANK: begin
        if (h_wrap) begin
          h_cnt_d = '0;
          if (v_cnt_q == VBLANK_LAST) begin
            v_cnt_d = '0;
            state_d = ST_ACTIVE;
            pat_d   = pattern_sel;
          end else begin
            v_cnt_d = v_cnt_q + 16'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 16'd1;
        end
      end
      ST_ACTIVE: begin
        if (h_wrap) begin
          h_cnt_d = '0;
          if (v_cnt_q == VACTIVE_LAST) begin
            v_cnt_d = '0;
            state_d = run ? ST_VBLANK : ST_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 16'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  // Outputs are the registered image of the current position, so they lag
  // the state by one cycle. frame_done fires on the first cycle after the
  // state has left ACTIVE while VS is still showing the last pixel.
  always_comb begin
    vs_d     = in_active;
    hs_d     = in_active && (h_cnt_q < H_ACT);
    data_d   = hs_d ? pixel_val : '0;
    fstart_d = in_active && (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
    fdone_d  = vs_q && !in_active;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      pat_q    <= '0;
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      data_q   <= '0;
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      pat_q    <= pat_d;
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      data_q   <= data_d;
      fstart_q <= fstart_d;
      fdone_q  <= fdone_d;
    end
  end

`ifdef CAMSRC_FRAME_TAG_EN
  // Frame number, advanced once per completed frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= 8'd0;
    end else if (fdone_q) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end
`endif

  assign MIPI_PIXEL_VS = vs_q;
  assign MIPI_PIXEL_HS = hs_q;
  assign MIPI_PIXEL_D  = data_q;
  assign frame_start   = fstart_q;
  assign frame_done    = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_frame_source
// Description : Self-checking bench for camera_frame_source. A position-based
//               frame model predicts every output cycle; directed scenarios
//               add hand-computed timing and pixel expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_frame_source;

  localparam int HA  = 4;
  localparam int HB  = 2;
  localparam int VA  = 3;
  localparam int VB  = 1;
  localparam int DW  = 10;
  localparam int L   = HA + HB;
  localparam int VBL = VB * L;
  localparam int P   = (VB + VA) * L;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          vs, hs, fs, fd;
  logic [DW-1:0] d;

  always #5 clk = ~clk;

  camera_frame_source #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .D_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .pattern_sel(pattern_sel),
    .MIPI_PIXEL_VS(vs), .MIPI_PIXEL_HS(hs), .MIPI_PIXEL_D(d),
    .frame_start(fs), .frame_done(fd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // One linear position 0..P-1 through blank+active time of a frame;
  // expected outputs at each edge are derived from the position held before it.
  logic          m_run = 1'b0;
  int            m_pos = 0;
  logic          m_done = 1'b0;
  logic [1:0]    m_pat = 2'd0;
  int            m_fc = 0;
  logic          e_vs = 1'b0, e_hs = 1'b0, e_fs = 1'b0, e_fd = 1'b0;
  logic [DW-1:0] e_d = '0;

  function automatic logic [DW-1:0] model_pix(input int pos, input logic [1:0] pat, input int fc);
    int h, v, val, mask;
    mask = (1 << DW) - 1;
    h = pos % L;
    v = (pos - VBL) / L;
    case (pat)
      2'd0:    val = h;
      2'd1:    val = v;
      2'd2:    val = (((h >> 3) ^ (v >> 3)) & 1) != 0 ? mask : 0;
      default: val = h ^ v;
    endcase
`ifdef CAMSRC_FRAME_TAG_EN
    if (h == 0 && v == 0) val = fc & 255;
`else
    if (fc < 0) val = 0;
`endif
    return DW'(val & mask);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0; m_pos <= 0; m_done <= 1'b0; m_pat <= 2'd0; m_fc <= 0;
      e_vs <= 1'b0; e_hs <= 1'b0; e_d <= '0; e_fs <= 1'b0; e_fd <= 1'b0;
    end else begin
      e_vs   <= m_run && (m_pos >= VBL);
      e_hs   <= m_run && (m_pos >= VBL) && ((m_pos % L) < HA);
      e_d    <= (m_run && (m_pos >= VBL) && ((m_pos % L) < HA)) ? model_pix(m_pos, m_pat, m_fc) : '0;
      e_fs   <= m_run && (m_pos == VBL);
      e_fd   <= m_done;
      m_done <= m_run && (m_pos == P - 1);
      if (m_run && (m_pos == P - 1)) m_fc <= m_fc + 1;
      if (!m_run) begin
        if (run) begin
          m_run <= 1'b1;
          m_pos <= 0;
        end
      end else if (m_pos == P - 1) begin
        m_pos <= 0;
        if (!run) m_run <= 1'b0;
      end else begin
        m_pos <= m_pos + 1;
        if (m_pos == VBL - 1) m_pat <= pattern_sel;
      end
    end
  end

  // ---------------- monitor state ----------------
  logic vs_prev = 1'b0;
  int   rise_q[$];
  int   fall_q[$];
  int   pix_q[$];
  int   tag_q[$];
  int   fs_cnt = 0;
  int   fd_cnt = 0;
  int   fd_at_fall = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle, compare against the model, record events.
  task automatic step();
    @(negedge clk);
    #1;
    chk("cycle_outputs", 32'({vs, hs, d, fs, fd}), 32'({e_vs, e_hs, e_d, e_fs, e_fd}));
    if (vs && !vs_prev) rise_q.push_back(cyc);
    if (!vs && vs_prev) begin
      fall_q.push_back(cyc);
      if (fd) fd_at_fall++;
    end
    if (fs) begin
      fs_cnt++;
      tag_q.push_back(int'(d));
    end
    if (fd) fd_cnt++;
    if (hs) pix_q.push_back(int'(d));
    vs_prev = vs;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    step();
    step();
    chk("reset_outputs", 32'({vs, hs, d, fs, fd}), 0);
    reset = 1'b1;
    step();
  endtask

  int k, br, bf, bp, bfs, bfd, bff, bt;
  int exp_c[24] = '{0,1,2,3, 1,0,3,2, 2,3,0,1, 0,0,0,0, 1,1,1,1, 2,2,2,2};

  initial begin
    // ---- A: start-up latency, 3 back-to-back frames, ramp pattern ----
    do_reset();
    br = rise_q.size(); bf = fall_q.size(); bp = pix_q.size();
    bfs = fs_cnt; bfd = fd_cnt; bff = fd_at_fall;
    pattern_sel = 2'd0;
    run = 1'b1;
    k = cyc + 1;
    while (cyc < k + 3 * P + 2) step();
    chk("a_rise_count", rise_q.size() - br, 3);
    chk("a_fall_count", fall_q.size() - bf, 3);
    if (rise_q.size() - br >= 3 && fall_q.size() - bf >= 1) begin
      chk("a_first_rise", rise_q[br] - k, 7);
      chk("a_vs_high", fall_q[bf] - rise_q[br], 18);
      chk("a_rise_gap1", rise_q[br + 1] - rise_q[br], 24);
      chk("a_rise_gap2", rise_q[br + 2] - rise_q[br + 1], 24);
    end
    chk("a_frame_start", fs_cnt - bfs, 3);
    chk("a_frame_done", fd_cnt - bfd, 3);
    chk("a_done_at_fall", fd_at_fall - bff, 3);
    if (pix_q.size() - bp >= 12) begin
      for (int i = 0; i < 12; i++) chk("a_ramp_pix", pix_q[bp + i], i % 4);
    end else begin
      chk("a_pix_count", pix_q.size() - bp, 12);
    end
    run = 1'b0;
    repeat (40) step();

    // ---- B: run dropped after second active pixel ----
    do_reset();
    br = rise_q.size(); bp = pix_q.size(); bfs = fs_cnt; bfd = fd_cnt;
    run = 1'b1;
    for (int i = 0; i < 40 && (pix_q.size() - bp) < 2; i++) step();
    chk("b_reach_active", (pix_q.size() - bp) >= 2 ? 1 : 0, 1);
    run = 1'b0;
    repeat (40) step();
    chk("b_pix_count", pix_q.size() - bp, 12);
    chk("b_frame_start", fs_cnt - bfs, 1);
    chk("b_frame_done", fd_cnt - bfd, 1);
    chk("b_rise_count", rise_q.size() - br, 1);
    chk("b_idle_outputs", 32'({vs, hs, d, fs, fd}), 0);

    // ---- C: XOR pattern, switched to vertical ramp mid-frame ----
    do_reset();
    bp = pix_q.size(); bfd = fd_cnt;
    pattern_sel = 2'd3;
    run = 1'b1;
    for (int i = 0; i < 40 && (pix_q.size() - bp) < 5; i++) step();
    pattern_sel = 2'd1;
    for (int i = 0; i < 200 && (fd_cnt - bfd) < 2; i++) step();
    chk("c_two_frames", fd_cnt - bfd, 2);
    run = 1'b0;
    if (pix_q.size() - bp >= 24) begin
      for (int i = 0; i < 24; i++) chk("c_pattern_pix", pix_q[bp + i], exp_c[i]);
    end else begin
      chk("c_pix_count", pix_q.size() - bp, 24);
    end
    repeat (40) step();

    // ---- D: asynchronous reset mid-ACTIVE, then restart ----
    do_reset();
    bp = pix_q.size();
    pattern_sel = 2'd0;
    run = 1'b1;
    for (int i = 0; i < 40 && (pix_q.size() - bp) < 5; i++) step();
    chk("d_reach_active", 32'(vs), 1);
    bfd = fd_cnt;
    #2;
    reset = 1'b0;
    #1;
    chk("d_async_clear", 32'({vs, hs, d, fs, fd}), 0);
    step();
    step();
    br = rise_q.size();
    reset = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 40 && rise_q.size() == br; i++) step();
    chk("d_restart_rise", (rise_q.size() > br) ? rise_q[br] - k : -1, 7);
    chk("d_no_done", fd_cnt - bfd, 0);
    run = 1'b0;
    repeat (40) step();

    // ---- E: pixel (0,0) across three frames, vertical ramp ----
    do_reset();
    bt = tag_q.size(); bfs = fs_cnt;
    pattern_sel = 2'd1;
    run = 1'b1;
    for (int i = 0; i < 200 && (fs_cnt - bfs) < 3; i++) step();
    run = 1'b0;
    chk("e_frame_count", fs_cnt - bfs, 3);
    if (tag_q.size() - bt >= 3) begin
      for (int i = 0; i < 3; i++) begin
`ifdef CAMSRC_FRAME_TAG_EN
        chk("e_first_pixel", tag_q[bt + i], i);
`else
        chk("e_first_pixel", tag_q[bt + i], 0);
`endif
      end
    end
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
